// File: rtl/iir_pkg.sv
// Shared definitions for the IIR input pacer: sample width, IIR cycle count
// and the pacer state encoding.
package iir_pkg;

  localparam int SAMPLE_W   = 18;
  localparam int IIR_CYCLES = 7;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [0:0] {
    PACER_IDLE = 1'b0,
    PACER_WAIT = 1'b1
  } pacer_state_e;

endpackage

// File: rtl/iir_sample_fifo.sv
// Small synchronous sample FIFO with binary pointers one bit wider than the
// address, so full/empty come straight from a pointer compare.
module iir_sample_fifo #(
  parameter int  DEPTH    = 8,
  parameter int  SAMPLE_W = 18,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [SAMPLE_W-1:0] push_data_i,
  input  logic                pop_i,
  output logic [SAMPLE_W-1:0] head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [AW:0]         level_o
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic                push_ok;
  logic                pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/iir_in_pacer.sv
// Feeds buffered samples to the IIR section as single-cycle strobes, spaced at
// least MIN_GAP cycles apart and optionally gated by the IIR's done pulse.
//
//   state | meaning
//   IDLE  | ready to issue once data, gap and done conditions allow
//   WAIT  | sample issued, din held, waiting out gap (and done)
module iir_in_pacer
  import iir_pkg::*;
#(
  parameter int  DEPTH    = 8,
  parameter int  MIN_GAP  = IIR_CYCLES,
  parameter int  USE_DONE = 1,
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic signed [SAMPLE_W-1:0] m_data,
  output logic                       m_valid,
  input  logic                       iir_done,
  output logic [LW-1:0]              level,
  output logic                       ovf
);

  localparam int          GW       = $clog2(MIN_GAP + 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(MIN_GAP);
  localparam logic [GW-1:0] GAP_EXIT = GW'(MIN_GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [0:0]  ST_IDLE  = PACER_IDLE;
  localparam logic [0:0]  ST_WAIT  = PACER_WAIT;

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          done_seen_q, done_seen_d;
  logic          first_q, first_d;
  logic          ovf_q, ovf_d;
  sample_t       m_data_q, m_data_d;

  logic                push;
  logic                issue;
  logic                done_ok;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;

  assign s_ready = !fifo_full;
  assign push    = s_valid && s_ready;
  assign done_ok = (USE_DONE == 0) || done_seen_q || first_q;
  assign issue   = (state_q == ST_IDLE) && !fifo_empty && (gap_q >= GAP_MAX) && done_ok;

  // The issue strobe is decoded from registered state only, so a push lands
  // in the FIFO one edge before it can be issued; the head is shown on the
  // issue cycle itself and latched for the rest of the processing window.
  assign m_valid = issue;
  assign m_data  = issue ? sample_t'(fifo_head) : m_data_q;
  assign ovf     = ovf_q;

  iir_sample_fifo #(
    .DEPTH    (DEPTH),
    .SAMPLE_W (SAMPLE_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (s_data),
    .pop_i       (issue),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  always_comb begin
    state_d     = state_q;
    done_seen_d = done_seen_q;
    first_d     = first_q;
    m_data_d    = m_data_q;
    ovf_d       = ovf_q | (s_valid & ~s_ready);

    if (issue) begin
      gap_d = GAP_ONE;
    end else if (gap_q < GAP_MAX) begin
      gap_d = gap_q + GAP_ONE;
    end else begin
      gap_d = gap_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          m_data_d    = sample_t'(fifo_head);
          done_seen_d = 1'b0;
          first_d     = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (iir_done) done_seen_d = 1'b1;
        // Leaving one cycle early lets the next issue land exactly MIN_GAP
        // after the previous one when done arrives on time.
        if ((gap_q >= GAP_EXIT) && ((USE_DONE == 0) || done_seen_q || iir_done)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gap_q       <= GAP_MAX;
      done_seen_q <= 1'b0;
      first_q     <= 1'b1;
      ovf_q       <= 1'b0;
      m_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      done_seen_q <= done_seen_d;
      first_q     <= first_d;
      ovf_q       <= ovf_d;
      m_data_q    <= m_data_d;
    end
  end

endmodule

// File: tb/tb_iir_in_pacer.sv
// Self-checking bench for iir_in_pacer: a queue-and-timestamp reference model
// predicts every output each cycle; scenario tasks add targeted checks.
module tb_iir_in_pacer;

  localparam int DEPTH   = 8;
  localparam int MIN_GAP = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [17:0] m_data;
  logic        m_valid;
  logic        iir_done = 1'b0;
  logic [3:0]  level;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iir_in_pacer #(.DEPTH(DEPTH), .MIN_GAP(MIN_GAP), .USE_DONE(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .iir_done (iir_done),
    .level    (level),
    .ovf      (ovf)
  );

  // Reference model: sample queue plus timestamps of the last issue and of
  // the first done pulse after it. Issue allowed once the queue is non-empty
  // and either this is the first issue since reset, or MIN_GAP cycles have
  // passed since the last issue and a done arrived before this cycle.
  logic [17:0] mq[$];
  bit          first_m = 1'b1;
  bit          done_after = 1'b0;
  bit          ovf_m = 1'b0;
  int          last_iss = -100;
  int          done_cyc = -100;
  int          done_at = -100;
  int          cyc = 0;
  int          now = 0;
  logic [17:0] hold_m = '0;
  bit          auto_done = 1'b0;
  bit          man_done = 1'b0;

  logic        exp_valid, exp_ready, exp_ovf;
  logic [17:0] exp_data;
  logic [3:0]  exp_level;

  task automatic cycle(input bit r, input bit sv, input logic [17:0] sd);
    bit allowed;
    bit dn;
    @(posedge clk); #1;
    dn = man_done || (auto_done && (cyc == done_at));
    rst = r; s_valid = sv; s_data = sd; iir_done = dn;
    now = cyc;
    exp_level = 4'(mq.size());
    exp_ready = (mq.size() < DEPTH);
    exp_ovf   = ovf_m;
    if (!first_m && dn && !done_after && cyc > last_iss) begin
      done_after = 1'b1;
      done_cyc   = cyc;
    end
    allowed = first_m || ((cyc - last_iss >= MIN_GAP) && done_after && (cyc > done_cyc));
    exp_valid = (mq.size() > 0) && allowed;
    if (exp_valid) begin
      hold_m     = mq.pop_front();
      last_iss   = cyc;
      first_m    = 1'b0;
      done_after = 1'b0;
      done_at    = cyc + MIN_GAP - 1;
    end
    exp_data = hold_m;
    if (sv) begin
      if (exp_ready) mq.push_back(sd);
      else ovf_m = 1'b1;
    end
    if (r) begin
      mq.delete();
      first_m = 1'b1; done_after = 1'b0; ovf_m = 1'b0; hold_m = '0;
      last_iss = -100; done_cyc = -100; done_at = -100; cyc = 0;
    end else begin
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    auto_done = 0; man_done = 0;
    cycle(1, 0, '0);
    cycle(1, 0, '0);
    cycle(0, 0, '0);
    total++; if (level !== 4'd0)   begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    total++; if (m_data !== 18'h0) begin bad++; $display("FAIL reset_m_data got=%h want=0", m_data); end
    total++; if (ovf !== 1'b0)     begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
  endtask

  task automatic test_single();
    auto_done = 1; man_done = 0;
    cycle(1, 0, '0);
    for (int i = 0; i < 12; i++) begin
      cycle(0, i == 0, 18'h00123);
      total++;
      if ({m_valid, s_ready, ovf, level, m_data} !== {exp_valid, exp_ready, exp_ovf, exp_level, exp_data}) begin
        bad++;
        $display("FAIL single_model cyc=%0d got v=%b r=%b o=%b l=%0d d=%h want v=%b r=%b o=%b l=%0d d=%h",
                 now, m_valid, s_ready, ovf, level, m_data, exp_valid, exp_ready, exp_ovf, exp_level, exp_data);
      end
      if (i == 1) begin
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL single_issue_c1 got=%b want=1", m_valid); end
      end
      if (i >= 1 && i <= 7) begin
        total++; if (m_data !== 18'h00123) begin bad++; $display("FAIL single_hold cyc=%0d got=%h want=00123", i, m_data); end
      end
      if (i == 2) begin
        total++; if (level !== 4'd0) begin bad++; $display("FAIL single_level got=%0d want=0", level); end
      end
    end
  endtask

  task automatic test_burst();
    int t_q[$];
    logic [17:0] d_q[$];
    auto_done = 1; man_done = 0;
    cycle(1, 0, '0);
    for (int i = 0; i < 40; i++) begin
      cycle(0, i < 5, 18'(i + 1));
      total++;
      if ({m_valid, s_ready, ovf, level, m_data} !== {exp_valid, exp_ready, exp_ovf, exp_level, exp_data}) begin
        bad++;
        $display("FAIL burst_model cyc=%0d got v=%b l=%0d d=%h want v=%b l=%0d d=%h",
                 now, m_valid, level, m_data, exp_valid, exp_level, exp_data);
      end
      if (m_valid === 1'b1) begin t_q.push_back(i); d_q.push_back(m_data); end
    end
    total++;
    if (t_q.size() != 5) begin
      bad++; $display("FAIL burst_count got=%0d want=5", t_q.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        total++;
        if (t_q[j] != 1 + MIN_GAP * j || d_q[j] !== 18'(j + 1)) begin
          bad++;
          $display("FAIL burst_issue%0d got cyc=%0d d=%h want cyc=%0d d=%h", j, t_q[j], d_q[j], 1 + MIN_GAP * j, j + 1);
        end
      end
    end
  endtask

  task automatic test_fill_ovf();
    int issues = 0;
    auto_done = 0; man_done = 0;
    cycle(1, 0, '0);
    for (int i = 0; i < 30; i++) begin
      cycle(0, i < 10, 18'(32'h100 + i));
      total++;
      if ({m_valid, s_ready, ovf, level, m_data} !== {exp_valid, exp_ready, exp_ovf, exp_level, exp_data}) begin
        bad++;
        $display("FAIL fill_model cyc=%0d got v=%b r=%b o=%b l=%0d want v=%b r=%b o=%b l=%0d",
                 now, m_valid, s_ready, ovf, level, exp_valid, exp_ready, exp_ovf, exp_level);
      end
      if (m_valid === 1'b1) issues++;
      if (i == 9) begin
        total++;
        if (s_ready !== 1'b0 || level !== 4'd8) begin
          bad++; $display("FAIL fill_full got r=%b l=%0d want r=0 l=8", s_ready, level);
        end
      end
    end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b want=1", ovf); end
    total++; if (issues != 1)  begin bad++; $display("FAIL fill_issues got=%0d want=1", issues); end
  endtask

  task automatic test_simul_push_pop();
    auto_done = 0; man_done = 0;
    cycle(1, 0, '0);
    for (int i = 0; i < 15; i++) begin
      man_done = (i == 9);
      cycle(0, (i < 9) || (i == 11), 18'(32'h200 + i));
      total++;
      if ({m_valid, s_ready, ovf, level, m_data} !== {exp_valid, exp_ready, exp_ovf, exp_level, exp_data}) begin
        bad++;
        $display("FAIL pp8_model cyc=%0d got v=%b l=%0d d=%h want v=%b l=%0d d=%h",
                 now, m_valid, level, m_data, exp_valid, exp_level, exp_data);
      end
      if (i == 10) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== 18'h201 || level !== 4'd8) begin
          bad++; $display("FAIL pp8_pop got v=%b d=%h l=%0d want v=1 d=00201 l=8", m_valid, m_data, level);
        end
      end
      if (i == 12) begin
        total++; if (level !== 4'd8) begin bad++; $display("FAIL pp8_refill got=%0d want=8", level); end
      end
    end
    man_done = 0; auto_done = 1;
    cycle(1, 0, '0);
    for (int i = 0; i < 13; i++) begin
      cycle(0, (i == 0) || (i == 2) || (i == 8), 18'(32'h300 + i));
      total++;
      if ({m_valid, s_ready, ovf, level, m_data} !== {exp_valid, exp_ready, exp_ovf, exp_level, exp_data}) begin
        bad++;
        $display("FAIL pp1_model cyc=%0d got v=%b l=%0d d=%h want v=%b l=%0d d=%h",
                 now, m_valid, level, m_data, exp_valid, exp_level, exp_data);
      end
      if (i == 8) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== 18'h302 || level !== 4'd1) begin
          bad++; $display("FAIL pp1_pop got v=%b d=%h l=%0d want v=1 d=00302 l=1", m_valid, m_data, level);
        end
      end
      if (i == 9) begin
        total++; if (level !== 4'd1) begin bad++; $display("FAIL pp1_level got=%0d want=1", level); end
      end
    end
  endtask

  task automatic test_wrap_random();
    logic [17:0] src[20];
    logic [17:0] got[$];
    logic [17:0] v;
    int idx = 0;
    bit sv;
    src[0] = 18'h3FFFF; src[1] = 18'h20000; src[2] = 18'h00001;
    for (int k = 3; k < 20; k++) src[k] = 18'($urandom);
    auto_done = 1; man_done = 0;
    cycle(1, 0, '0);
    for (int i = 0; i < 400 && got.size() < 20; i++) begin
      sv = (idx < 20) && (mq.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      v  = (idx < 20) ? src[idx] : 18'h0;
      cycle(0, sv, v);
      if (sv) idx++;
      total++;
      if ({m_valid, s_ready, ovf, level, m_data} !== {exp_valid, exp_ready, exp_ovf, exp_level, exp_data}) begin
        bad++;
        $display("FAIL wrap_model cyc=%0d got v=%b l=%0d d=%h want v=%b l=%0d d=%h",
                 now, m_valid, level, m_data, exp_valid, exp_level, exp_data);
      end
      if (m_valid === 1'b1) got.push_back(m_data);
    end
    total++;
    if (got.size() != 20) begin
      bad++; $display("FAIL wrap_count got=%0d want=20", got.size());
    end else begin
      for (int j = 0; j < 20; j++) begin
        total++;
        if (got[j] !== src[j]) begin bad++; $display("FAIL wrap_data%0d got=%h want=%h", j, got[j], src[j]); end
      end
    end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b want=0", ovf); end
  endtask

  task automatic test_mid_reset();
    auto_done = 0; man_done = 0;
    cycle(1, 0, '0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, i < 4, 18'(32'h40 + i));
      total++;
      if ({m_valid, s_ready, ovf, level, m_data} !== {exp_valid, exp_ready, exp_ovf, exp_level, exp_data}) begin
        bad++;
        $display("FAIL mrst_model cyc=%0d got v=%b l=%0d d=%h want v=%b l=%0d d=%h",
                 now, m_valid, level, m_data, exp_valid, exp_level, exp_data);
      end
    end
    total++; if (level !== 4'd3) begin bad++; $display("FAIL mrst_pre_level got=%0d want=3", level); end
    cycle(1, 0, '0);
    cycle(0, 1, 18'h00077);
    total++;
    if (level !== 4'd0 || m_data !== 18'h0 || m_valid !== 1'b0 || ovf !== 1'b0 || s_ready !== 1'b1) begin
      bad++; $display("FAIL mrst_after got l=%0d d=%h v=%b o=%b r=%b want l=0 d=0 v=0 o=0 r=1",
                      level, m_data, m_valid, ovf, s_ready);
    end
    cycle(0, 0, '0);
    total++;
    if (m_valid !== 1'b1 || m_data !== 18'h00077) begin
      bad++; $display("FAIL mrst_first_issue got v=%b d=%h want v=1 d=00077", m_valid, m_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_fill_ovf();
    test_simul_push_pop();
    test_wrap_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
